// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage. Runs a req/ack data-RAM transaction
// for loads and stores, stalls the pipeline until the bus acknowledges, and
// aligns/extends load data into a registered writeback bundle.
// Optional feature macro: MEM_MISALIGN_EXC_EN (misaligned access trap, adds
// exc_misalign / exc_badaddr ports).
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_ramAddr,
  input  logic [3:0]  mem_ramSel,
  input  logic [2:0]  mem_loadop,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        stall_req,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
`ifdef MEM_MISALIGN_EXC_EN
  output logic        exc_misalign,
  output logic [31:0] exc_badaddr,
`endif
  output logic        bus_err
);

  localparam logic [2:0] MEM_LOADOP_NOP = 3'd0;
  localparam logic [2:0] MEM_LOADOP_LB  = 3'd1;
  localparam logic [2:0] MEM_LOADOP_LBU = 3'd2;
  localparam logic [2:0] MEM_LOADOP_LH  = 3'd3;
  localparam logic [2:0] MEM_LOADOP_LHU = 3'd4;
  localparam logic [2:0] MEM_LOADOP_LW  = 3'd5;

  localparam logic [7:0] LP_TIMEOUT = 8'(ACK_TIMEOUT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_lo;
  logic [2:0]  r_loadop;
  logic [4:0]  r_waddr;
  logic        r_wreg;

  logic        w_is_load, w_access, w_misalign, w_start;
  logic        w_cnt_done, w_ack, w_timeout;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  // Request decode: access detection, bus byte enables, misalignment
  always_comb begin
    w_is_load = (mem_loadop != MEM_LOADOP_NOP);
    w_access  = mem_valid & (w_is_load | (mem_ramSel != 4'b0000));
    case (mem_loadop)
      MEM_LOADOP_LB, MEM_LOADOP_LBU: w_sel = 4'b0001 << mem_ramAddr[1:0];
      MEM_LOADOP_LH, MEM_LOADOP_LHU: w_sel = mem_ramAddr[1] ? 4'b1100 : 4'b0011;
      MEM_LOADOP_LW:                 w_sel = 4'b1111;
      default:                       w_sel = mem_ramSel;
    endcase
`ifdef MEM_MISALIGN_EXC_EN
    w_misalign = w_access & (
      ((mem_loadop == MEM_LOADOP_LH) | (mem_loadop == MEM_LOADOP_LHU) |
       (~w_is_load & ((mem_ramSel == 4'b0011) | (mem_ramSel == 4'b1100)))) & mem_ramAddr[0] |
      ((mem_loadop == MEM_LOADOP_LW) | (~w_is_load & (mem_ramSel == 4'b1111))) &
       (mem_ramAddr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;
    w_cnt_done = (r_cnt == LP_TIMEOUT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BUSY;
      S_BUSY:  if (ram_ack || w_cnt_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state outputs: ack/timeout qualification and pipeline stall
  always_comb begin
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    stall_req = 1'b0;
    case (r_state)
      S_IDLE: stall_req = w_access & ~w_misalign;
      S_BUSY: begin
        w_ack     = ram_ack;
        w_timeout = ~ram_ack & w_cnt_done;
        stall_req = ~ram_ack & ~w_cnt_done;
      end
      default: stall_req = 1'b0;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    case (r_lo)
      2'd0:    w_byte = ram_rdata[7:0];
      2'd1:    w_byte = ram_rdata[15:8];
      2'd2:    w_byte = ram_rdata[23:16];
      default: w_byte = ram_rdata[31:24];
    endcase
    w_half = r_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r_loadop)
      MEM_LOADOP_LB:  w_ldata = {{24{w_byte[7]}}, w_byte};
      MEM_LOADOP_LBU: w_ldata = {24'h0, w_byte};
      MEM_LOADOP_LH:  w_ldata = {{16{w_half[15]}}, w_half};
      MEM_LOADOP_LHU: w_ldata = {16'h0, w_half};
      MEM_LOADOP_LW:  w_ldata = ram_rdata;
      default:        w_ldata = ram_wdata;
    endcase
  end

  // Bus request registers, transaction latches, timeout counter, WB bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_sel   <= '0;
      ram_wdata <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_loadop  <= '0;
      r_waddr   <= '0;
      r_wreg    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wreg   <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          ram_req   <= 1'b1;
          ram_we    <= ~w_is_load;
          ram_addr  <= {mem_ramAddr[31:2], 2'b00};
          ram_sel   <= w_sel;
          ram_wdata <= mem_wdata;
          r_cnt     <= '0;
          r_lo      <= mem_ramAddr[1:0];
          r_loadop  <= mem_loadop;
          r_waddr   <= mem_waddr;
          r_wreg    <= mem_wreg;
          wb_valid  <= 1'b0;
          wb_wreg   <= 1'b0;
        end else begin
          wb_valid <= mem_valid;
          wb_wreg  <= mem_wreg & ~w_misalign;
          wb_waddr <= mem_waddr;
          wb_wdata <= mem_wdata;
        end
      end else if (w_ack) begin
        ram_req  <= 1'b0;
        ram_we   <= 1'b0;
        wb_valid <= 1'b1;
        wb_wreg  <= r_wreg & (r_loadop != MEM_LOADOP_NOP);
        wb_waddr <= r_waddr;
        wb_wdata <= w_ldata;
      end else if (w_timeout) begin
        ram_req  <= 1'b0;
        ram_we   <= 1'b0;
        bus_err  <= 1'b1;
        wb_valid <= 1'b1;
        wb_wreg  <= 1'b0;
        wb_waddr <= r_waddr;
        wb_wdata <= ram_wdata;
      end else begin
        r_cnt    <= r_cnt + 8'd1;
        wb_valid <= 1'b0;
        wb_wreg  <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  // Misalignment trap: pulse plus faulting address, aligned with the WB bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_misalign <= 1'b0;
      exc_badaddr  <= '0;
    end else begin
      exc_misalign <= (r_state == S_IDLE) & w_misalign;
      if ((r_state == S_IDLE) && w_misalign) exc_badaddr <= mem_ramAddr;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: random and directed instruction stream,
// bus responder with programmable ack latency, scoreboarded WB checking.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int unsigned TO = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_ramAddr;
  logic [3:0]  mem_ramSel;
  logic [2:0]  mem_loadop;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic        stall_req, wb_valid, wb_wreg, bus_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
`ifdef MEM_MISALIGN_EXC_EN
  logic        exc_misalign;
  logic [31:0] exc_badaddr;
`endif

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ramAddr(mem_ramAddr), .mem_ramSel(mem_ramSel),
    .mem_loadop(mem_loadop),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
`ifdef MEM_MISALIGN_EXC_EN
    .exc_misalign(exc_misalign), .exc_badaddr(exc_badaddr),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        valid, wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata, addr;
    logic [3:0]  sel;
    logic [2:0]  op;
  } instr_t;

  typedef struct {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        chk_data, err, mis;
    logic [31:0] bad;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        we;
    int unsigned d, cyc;
  } bus_exp_t;

  wb_exp_t  wbq[$];
  bus_exp_t busq[$];
  int       n_cmp = 0, n_bad = 0;
  logic     resp_en = 1'b1, inj_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic int unsigned acc_size(instr_t i);
    if (i.op == 3'd1 || i.op == 3'd2) return 1;
    if (i.op == 3'd3 || i.op == 3'd4) return 2;
    if (i.op == 3'd5) return 4;
    return $countones(i.sel);
  endfunction

  function automatic bit misaligned(instr_t i);
`ifdef MEM_MISALIGN_EXC_EN
    return (i.addr % acc_size(i)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] rdata, logic [31:0] addr, logic [2:0] op);
    int unsigned sz, off;
    logic [31:0] v, m;
    sz  = (op <= 3'd2) ? 1 : (op <= 3'd4) ? 2 : 4;
    off = (addr % 4) / sz * sz;
    v   = rdata >> (8 * off);
    if (sz == 4) return v;
    m = (32'h1 << (8 * sz)) - 1;
    v = v & m;
    if ((op == 3'd1 || op == 3'd3) && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  function automatic instr_t mk(logic v, logic wr, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] a, logic [3:0] s, logic [2:0] op);
    instr_t i;
    i.valid = v; i.wreg = wr; i.waddr = wa; i.wdata = wd; i.addr = a; i.sel = s; i.op = op;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int unsigned k, sz;
    k = $urandom_range(0, 9);
    i = mk(1'b1, 1'($urandom), 5'($urandom), $urandom, $urandom, 4'h0, 3'd0);
    if (k >= 3 && k < 6) begin
      i.op = 3'($urandom_range(1, 5));
    end else if (k >= 6 && k < 9) begin
      sz = 1 << $urandom_range(0, 2);
      i.sel = 4'(((1 << sz) - 1) << ((i.addr % 4) / sz * sz));
      if (sz == 1) i.wdata = {4{i.wdata[7:0]}};
      else if (sz == 2) i.wdata = {2{i.wdata[15:0]}};
    end else if (k == 9) begin
      i.valid = 1'b0;
      i.op = 3'($urandom_range(0, 5));
      i.sel = 4'($urandom);
    end
    return i;
  endfunction

  // Present one instruction to MEM, record expectations, hold it until consumed.
  task automatic issue(input instr_t i, input logic [31:0] rdata, input int unsigned d);
    wb_exp_t     w;
    bus_exp_t    b;
    int unsigned occ, exp_occ, sz, off;
    logic        s;
    bit          acc, mis;
    mem_valid = i.valid; mem_wreg = i.wreg; mem_waddr = i.waddr; mem_wdata = i.wdata;
    mem_ramAddr = i.addr; mem_ramSel = i.sel; mem_loadop = i.op;
    acc = i.valid && (i.op != 3'd0 || i.sel != 4'h0);
    mis = acc && misaligned(i);
    exp_occ = 1;
    if (acc && !mis) begin
      sz = acc_size(i);
      off = (i.addr % 4) / sz * sz;
      b.addr  = i.addr & ~32'h3;
      b.sel   = (i.op != 3'd0) ? 4'(((1 << sz) - 1) << off) : i.sel;
      b.we    = (i.op == 3'd0);
      b.wdata = i.wdata;
      b.rdata = rdata;
      b.d     = d;
      b.cyc   = cyc;
      busq.push_back(b);
      exp_occ = (d > TO) ? TO + 2 : d + 2;
    end
    if (i.valid) begin
      w.wreg = i.wreg; w.waddr = i.waddr; w.wdata = i.wdata;
      w.chk_data = 1'b1; w.err = 1'b0; w.mis = 1'b0; w.bad = '0;
      if (mis) begin
        w.wreg = 1'b0; w.chk_data = 1'b0; w.mis = 1'b1; w.bad = i.addr;
      end else if (acc && d > TO) begin
        w.wreg = 1'b0; w.chk_data = 1'b0; w.err = 1'b1;
      end else if (acc && i.op != 3'd0) begin
        w.wdata = load_val(rdata, i.addr, i.op);
      end else if (acc) begin
        w.wreg = 1'b0; w.chk_data = 1'b0;
      end
      wbq.push_back(w);
    end
    occ = 0;
    do begin
      @(negedge clk); s = stall_req;
      @(posedge clk); #1;
      occ++;
    end while (s && occ < TO + 20);
    check("mem_occupancy", occ, exp_occ);
  endtask

  task automatic bubble();
    mem_valid = 1'b0; mem_wreg = 1'b0; mem_waddr = '0; mem_wdata = '0;
    mem_ramAddr = '0; mem_ramSel = '0; mem_loadop = '0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    bubble();
    while ((wbq.size() != 0 || busq.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain_left", wbq.size() + busq.size(), 0);
  endtask

  // ---- bus responder: checks each request, acks after the programmed delay ----
  initial begin
    bus_exp_t    cur;
    bit          busy = 0, changed = 0;
    int unsigned w = 0;
    ram_ack = 1'b0; ram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      ram_ack = 1'b0;
      ram_rdata = $urandom;
      if (rst || !resp_en) begin
        busy = 0;
        ram_ack = inj_ack;
      end else if (!busy) begin
        if (ram_req) begin
          if (busq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_req: ram_req high at addr %h with no access pending", ram_addr);
          end else begin
            cur = busq.pop_front();
            check("req_latency", cyc, cur.cyc + 1);
            check("ram_addr", ram_addr, cur.addr);
            check("ram_sel", ram_sel, cur.sel);
            check("ram_we", ram_we, cur.we);
            if (cur.we) check("ram_wdata", ram_wdata, cur.wdata);
            busy = 1; w = 0; changed = 0;
            if (cur.d == 0) begin
              ram_ack = 1'b1; ram_rdata = cur.rdata; busy = 0;
            end
          end
        end
      end else begin
        w++;
        if (!ram_req || w > TO + 1) begin
          check("req_drop_cycle", w, TO + 1);
          check("bus_hold", changed, 0);
          busy = 0;
        end else begin
          if (ram_addr !== cur.addr || ram_sel !== cur.sel || ram_we !== cur.we ||
              (cur.we && ram_wdata !== cur.wdata)) changed = 1;
          if (w == cur.d) begin
            check("bus_hold", changed, 0);
            ram_ack = 1'b1; ram_rdata = cur.rdata; busy = 0;
          end
        end
      end
    end
  end

  // ---- WB monitor ----
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_valid) begin
          if (wbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_unexpected: wb_valid with waddr %h wdata %h, nothing expected", wb_waddr, wb_wdata);
          end else begin
            e = wbq.pop_front();
            check("wb_wreg", wb_wreg, e.wreg);
            check("wb_waddr", wb_waddr, e.waddr);
            if (e.chk_data) check("wb_wdata", wb_wdata, e.wdata);
            check("bus_err", bus_err, e.err);
`ifdef MEM_MISALIGN_EXC_EN
            check("exc_misalign", exc_misalign, e.mis);
            if (e.mis) check("exc_badaddr", exc_badaddr, e.bad);
`endif
          end
        end else begin
          if (bus_err) check("bus_err_no_wb", bus_err, 0);
`ifdef MEM_MISALIGN_EXC_EN
          if (exc_misalign) check("exc_misalign_no_wb", exc_misalign, 0);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---- main stimulus ----
  initial begin
    rst = 1'b1;
    bubble();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_sel", ram_sel, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_wreg", wb_wreg, 0);
    check("rst_wb_waddr", wb_waddr, 0);
    check("rst_wb_wdata", wb_wdata, 0);
    check("rst_bus_err", bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed cases
    issue(mk(1, 1, 5'd3, 32'h0, 32'h103, 4'h0, 3'd1), 32'h80FF7F01, 0);          // LB sign
    issue(mk(1, 1, 5'd4, 32'h0, 32'h202, 4'h0, 3'd4), 32'hBEEF1234, 1);          // LHU
    issue(mk(1, 1, 5'd5, 32'hDEADBEEF, 32'h40, 4'hF, 3'd0), 32'h0, 5);           // SW, slow ack
    issue(mk(1, 1, 5'd6, 32'h0, 32'h300, 4'h0, 3'd5), 32'h13579BDF, 0);          // LW
    issue(mk(1, 1, 5'd7, 32'hA5A5A5A5, 32'h0, 4'h0, 3'd0), 32'h0, 0);            // ALU op
    issue(mk(1, 1, 5'd8, 32'h0, 32'h302, 4'h0, 3'd3), 32'h8001FFFF, 0);          // LH sign
    issue(mk(1, 1, 5'd9, 32'h0, 32'h400, 4'h0, 3'd5), 32'h0, TO + 3);            // timeout
    issue(mk(1, 1, 5'd10, 32'h0, 32'h101, 4'h0, 3'd2), 32'h00AB0000, 0);         // LBU after abort
`ifdef MEM_MISALIGN_EXC_EN
    issue(mk(1, 1, 5'd11, 32'h0, 32'h1002, 4'h0, 3'd5), 32'h0, 0);               // misaligned LW
`endif

    // randomized stream
    for (int n = 0; n < 150; n++) begin
      int unsigned d;
      d = ($urandom_range(0, 9) == 0) ? TO + 3 : $urandom_range(0, 4);
      issue(rand_instr(), $urandom, d);
    end
    drain();

    // reset while BUSY, then a stray ack in IDLE
    resp_en = 1'b0;
    mem_valid = 1'b1; mem_wreg = 1'b1; mem_waddr = 5'd12; mem_wdata = '0;
    mem_ramAddr = 32'h80; mem_ramSel = 4'h0; mem_loadop = 3'd5;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_ram_req", ram_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bubble();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ram_req", ram_req, 0);
    check("midrst_ram_we", ram_we, 0);
    check("midrst_ram_addr", ram_addr, 0);
    check("midrst_ram_sel", ram_sel, 0);
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_bus_err", bus_err, 0);
    check("midrst_stall", stall_req, 0);
    inj_ack = 1'b1;
    @(negedge clk);
    check("late_ack_stall", stall_req, 0);
    inj_ack = 1'b0;
    @(negedge clk);
    check("late_ack_wb_valid", wb_valid, 0);
    check("late_ack_ram_req", ram_req, 0);
    @(posedge clk); #1;
    resp_en = 1'b1;
    issue(mk(1, 1, 5'd13, 32'h12345678, 32'h0, 4'h0, 3'd0), 32'h0, 0);
    issue(mk(1, 1, 5'd14, 32'h0, 32'h500, 4'h0, 3'd5), 32'hCAFEF00D, 2);
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
